// File: rtl/motor_pkg.sv
// Shared motor-command codes, FSM encoding and command sanitising for the
// soft-start H-bridge driver.
package motor_pkg;

  localparam logic [2:0] MS_STOP  = 3'd0;
  localparam logic [2:0] MS_FWD   = 3'd1;
  localparam logic [2:0] MS_BWD   = 3'd2;
  localparam logic [2:0] MS_LEFT  = 3'd3;
  localparam logic [2:0] MS_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Unused codes 5..7 must never reach the bridge as a direction.
  function automatic logic [2:0] sanitize_cmd(input logic [2:0] ms);
    return (ms > MS_RIGHT) ? MS_STOP : ms;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM: prescaler divides clk by PWM_DIV, an 8-bit counter
// wraps 255->0, and the output is high while the counter is below duty.
module pwm_gen #(
  parameter int PWM_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty,
  output logic       pwm_on
);

  localparam int PW = ($clog2(PWM_DIV) < 1) ? 1 : $clog2(PWM_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(PWM_DIV - 1);

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (presc == PRE_LAST) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/motor_pwm_ramp.sv
// Soft-start PWM driver for two L9110 channels with dead-time on reversal
// and immediate obstacle stop. Define MOTOR_BRAKE_EN to short-brake in IDLE.
module motor_pwm_ramp
  import motor_pkg::*;
#(
  parameter int PWM_DIV       = 16,
  parameter int RAMP_STEP_CYC = 100000,
  parameter int DUTY_MIN      = 64,
  parameter int DUTY_MAX      = 255,
  parameter int DEADTIME_CYC  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] motor_state,
  input  logic       obstacle_stop,
  output logic       A_1A,
  output logic       A_1B,
  output logic       B_1A,
  output logic       B_1B,
  output logic [7:0] duty,
  output logic       busy
);

  localparam int SW = ($clog2(RAMP_STEP_CYC) < 1) ? 1 : $clog2(RAMP_STEP_CYC);
  localparam int DW = ($clog2(DEADTIME_CYC) < 1) ? 1 : $clog2(DEADTIME_CYC);
  localparam logic [SW-1:0] STEP_LAST = SW'(RAMP_STEP_CYC - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_CYC - 1);
  localparam logic [7:0]    D_MIN     = 8'(DUTY_MIN);
  localparam logic [7:0]    D_MAX     = 8'(DUTY_MAX);
  localparam state_t        RAMP_ENTRY = (DUTY_MIN >= DUTY_MAX) ? ST_RUN : ST_RAMP;
`ifdef MOTOR_BRAKE_EN
  localparam logic [3:0]    IDLE_PINS = 4'b1111;
`else
  localparam logic [3:0]    IDLE_PINS = 4'b0000;
`endif

  logic [2:0]    cmd_q;
  logic          obs_q;
  state_t        state;
  logic [2:0]    dir;
  logic [7:0]    duty_q;
  logic [SW-1:0] step_tmr;
  logic [DW-1:0] dead_tmr;
  logic          pwm_on;
  logic [3:0]    pins;

  // Pin order {A_1A, A_1B, B_1A, B_1B}.
  function automatic logic [3:0] pin_map(input logic [2:0] d, input logic p);
    case (d)
      MS_FWD:   return {p, 1'b0, p, 1'b0};
      MS_BWD:   return {1'b0, p, 1'b0, p};
      MS_LEFT:  return {1'b0, p, p, 1'b0};
      MS_RIGHT: return {p, 1'b0, 1'b0, p};
      default:  return 4'b0000;
    endcase
  endfunction

  // Stage 0: register and sanitise the command inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= MS_STOP;
      obs_q <= 1'b0;
    end else begin
      cmd_q <= sanitize_cmd(motor_state);
      obs_q <= obstacle_stop;
    end
  end

  // Stage 1: ramp / dead-time FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      duty_q   <= '0;
      dir      <= MS_STOP;
      step_tmr <= '0;
      dead_tmr <= '0;
    end else if (obs_q) begin
      state  <= ST_IDLE;
      duty_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          duty_q <= '0;
          if (cmd_q != MS_STOP) begin
            dir      <= cmd_q;
            duty_q   <= D_MIN;
            step_tmr <= '0;
            state    <= RAMP_ENTRY;
          end
        end
        ST_RAMP, ST_RUN: begin
          if (cmd_q == MS_STOP) begin
            state  <= ST_IDLE;
            duty_q <= '0;
          end else if (cmd_q != dir) begin
            state    <= ST_DEAD;
            duty_q   <= '0;
            dead_tmr <= '0;
          end else if (state == ST_RAMP) begin
            if (step_tmr == STEP_LAST) begin
              step_tmr <= '0;
              if (({1'b0, duty_q} + 9'd1) >= {1'b0, D_MAX}) begin
                duty_q <= D_MAX;
                state  <= ST_RUN;
              end else begin
                duty_q <= duty_q + 8'd1;
              end
            end else begin
              step_tmr <= step_tmr + 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (dead_tmr == DEAD_LAST) begin
            if (cmd_q == MS_STOP) begin
              state <= ST_IDLE;
            end else begin
              dir      <= cmd_q;
              duty_q   <= D_MIN;
              step_tmr <= '0;
              state    <= RAMP_ENTRY;
            end
          end else begin
            dead_tmr <= dead_tmr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .duty  (duty_q),
    .pwm_on(pwm_on)
  );

  // Stage 2: registered bridge pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pins <= '0;
    end else begin
      case (state)
        ST_IDLE:         pins <= IDLE_PINS;
        ST_RAMP, ST_RUN: pins <= pin_map(dir, pwm_on);
        default:         pins <= '0;
      endcase
    end
  end

  assign {A_1A, A_1B, B_1A, B_1B} = pins;
  assign duty = duty_q;
  assign busy = (state == ST_RAMP) || (state == ST_DEAD);

endmodule
